// File: rtl/player_hit_detector.sv
// Player hit detector: checks obstacle pixels against the player box, tracks HP,
// and handles post-hit invulnerability and game over. Define HIT_COUNT_EN to add hit_count.
module player_hit_detector #(
   parameter int unsigned PLAYER_SIZE = 16,
   parameter int unsigned HP_MAX      = 5,
   parameter int unsigned HP_WIDTH    = 4,
   parameter int unsigned INVULN_TIME = 65000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                game_on,
   input  logic [11:0]         obstacle_x,
   input  logic [11:0]         obstacle_y,
   input  logic [11:0]         mouse_xpos,
   input  logic [11:0]         mouse_ypos,
   output logic [HP_WIDTH-1:0] hp,
   output logic                hit,
   output logic                invuln,
   output logic                game_over
`ifdef HIT_COUNT_EN
   ,
   output logic [7:0]          hit_count
`endif
);

   localparam int unsigned CNT_W = (INVULN_TIME > 1) ? $clog2(INVULN_TIME) : 1;
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(INVULN_TIME - 1);
   localparam logic [12:0]         SPAN     = 13'(PLAYER_SIZE - 1);
   localparam logic [HP_WIDTH-1:0] HP_FULL  = HP_WIDTH'(HP_MAX);
   localparam logic [HP_WIDTH-1:0] HP_ONE   = HP_WIDTH'(1);

   typedef enum logic [1:0] {StIdle, StArmed, StInvuln, StDead} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [11:0]      obs_x, obs_y, mx, my;

   logic        pix_valid, hit_det;
   logic [12:0] x_hi, y_hi;

   always_ff @(posedge clk) begin
      if (rst) begin
         obs_x <= '0;
         obs_y <= '0;
         mx    <= '0;
         my    <= '0;
      end else begin
         obs_x <= obstacle_x;
         obs_y <= obstacle_y;
         mx    <= mouse_xpos;
         my    <= mouse_ypos;
      end
   end

   // Upper bounds are 13 bits so a box near the right/bottom edge never wraps to 0.
   always_comb begin
      x_hi      = {1'b0, mx} + SPAN;
      y_hi      = {1'b0, my} + SPAN;
      pix_valid = (obs_x != '0) || (obs_y != '0);
      hit_det   = pix_valid &&
                  (obs_x >= mx) && ({1'b0, obs_x} <= x_hi) &&
                  (obs_y >= my) && ({1'b0, obs_y} <= y_hi);
   end

   always_ff @(posedge clk) begin
      if (rst || !game_on) begin
         state     <= StIdle;
         hp        <= HP_FULL;
         hit       <= 1'b0;
         invuln    <= 1'b0;
         game_over <= 1'b0;
         cnt       <= '0;
      end else begin
         hit <= 1'b0;
         unique case (state)
            StIdle: begin
               hp        <= HP_FULL;
               invuln    <= 1'b0;
               game_over <= 1'b0;
               cnt       <= '0;
               state     <= StArmed;
            end
            StArmed: begin
               if (hit_det) begin
                  hit <= 1'b1;
                  if (hp == HP_ONE) begin
                     hp        <= '0;
                     game_over <= 1'b1;
                     state     <= StDead;
                  end else begin
                     hp     <= hp - HP_ONE;
                     cnt    <= '0;
                     invuln <= 1'b1;
                     state  <= StInvuln;
                  end
               end
            end
            StInvuln: begin
               if (cnt == CNT_LAST) begin
                  cnt    <= '0;
                  invuln <= 1'b0;
                  state  <= StArmed;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            StDead: begin
               hp        <= '0;
               game_over <= 1'b1;
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifdef HIT_COUNT_EN
   // Counts exactly the hits that produce a hit pulse; saturates at 255.
   always_ff @(posedge clk) begin
      if (rst || !game_on || state == StIdle) begin
         hit_count <= '0;
      end else if (state == StArmed && hit_det && hit_count != 8'hFF) begin
         hit_count <= hit_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_player_hit_detector.sv
// Directed self-checking bench for player_hit_detector (PLAYER_SIZE=16, HP_MAX=3, INVULN_TIME=10).
// Define HIT_COUNT_EN to also check hit_count.
module tb_player_hit_detector;

   logic        clk = 1'b0;
   logic        rst;
   logic        game_on;
   logic [11:0] obstacle_x, obstacle_y, mouse_xpos, mouse_ypos;
   logic [3:0]  hp;
   logic        hit, invuln, game_over;
`ifdef HIT_COUNT_EN
   logic [7:0]  hit_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   player_hit_detector #(
      .PLAYER_SIZE(16),
      .HP_MAX     (3),
      .HP_WIDTH   (4),
      .INVULN_TIME(10)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .game_on   (game_on),
      .obstacle_x(obstacle_x),
      .obstacle_y(obstacle_y),
      .mouse_xpos(mouse_xpos),
      .mouse_ypos(mouse_ypos),
      .hp        (hp),
      .hit       (hit),
      .invuln    (invuln),
      .game_over (game_over)
`ifdef HIT_COUNT_EN
      ,
      .hit_count (hit_count)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_obs(input int x, input int y);
      obstacle_x = 12'(x);
      obstacle_y = 12'(y);
   endtask

   // One-cycle pixel; on return the outputs reflect that pixel (two edges later).
   task automatic pulse_pixel(input int x, input int y);
      set_obs(x, y);
      tick();
      set_obs(0, 0);
      tick();
   endtask

   task automatic wait_invuln_end(input string tag);
      int n = 0;
      while (invuln && n < 30) begin
         tick();
         n++;
      end
      check_eq(tag, 32'(invuln), 32'd0);
   endtask

   int  n_inv;
   logic hit_seen;
   logic hp_moved;

   initial begin
      rst = 1'b1;
      game_on = 1'b0;
      set_obs(0, 0);
      mouse_xpos = 12'd400;
      mouse_ypos = 12'd400;
      tick();
      tick();
      rst = 1'b0;
      check_eq("rst_hp", 32'(hp), 32'd3);
      check_eq("rst_hit", 32'(hit), 32'd0);
      check_eq("rst_invuln", 32'(invuln), 32'd0);
      check_eq("rst_game_over", 32'(game_over), 32'd0);

      // Idle: an in-box pixel does nothing.
      set_obs(405, 410);
      tick();
      tick();
      tick();
      check_eq("idle_hit", 32'(hit), 32'd0);
      check_eq("idle_hp", 32'(hp), 32'd3);

      // Start the game, then first hit.
      set_obs(0, 0);
      game_on = 1'b1;
      tick();
      tick();
      set_obs(405, 410);
      tick();
      set_obs(0, 0);
      check_eq("hit_latency_early", 32'(hit), 32'd0);
      tick();
      check_eq("hit1_pulse", 32'(hit), 32'd1);
      check_eq("hit1_hp", 32'(hp), 32'd2);
      check_eq("hit1_invuln", 32'(invuln), 32'd1);

      // Hold the pixel in the box throughout invulnerability: must be ignored.
      set_obs(405, 410);
      n_inv = 1;
      hit_seen = 1'b0;
      hp_moved = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (!invuln) break;
         n_inv++;
         hit_seen |= hit;
         hp_moved |= (hp != 4'd2);
      end
      check_eq("invuln_len", 32'(n_inv), 32'd10);
      check_eq("invuln_no_hit", 32'(hit_seen), 32'd0);
      check_eq("invuln_hp_kept", 32'(hp_moved), 32'd0);
      check_eq("invuln_end_hp", 32'(hp), 32'd2);

      // Same pixel still present once armed again.
      tick();
      set_obs(0, 0);
      check_eq("hit2_pulse", 32'(hit), 32'd1);
      check_eq("hit2_hp", 32'(hp), 32'd1);
      check_eq("hit2_invuln", 32'(invuln), 32'd1);
      tick();
      check_eq("hit2_one_cycle", 32'(hit), 32'd0);
      wait_invuln_end("hit2_invuln_end");

      // Box edge misses.
      pulse_pixel(416, 400);
      check_eq("miss_right_hit", 32'(hit), 32'd0);
      pulse_pixel(400, 399);
      check_eq("miss_above_hit", 32'(hit), 32'd0);
      pulse_pixel(0, 0);
      check_eq("no_pixel_hit", 32'(hit), 32'd0);
      mouse_xpos = 12'd4090;
      mouse_ypos = 12'd4090;
      pulse_pixel(5, 5);
      check_eq("nowrap_hit", 32'(hit), 32'd0);
      check_eq("misses_hp", 32'(hp), 32'd1);
      mouse_xpos = 12'd400;
      mouse_ypos = 12'd400;
      tick();

      // Bottom-right corner: third hit kills.
      pulse_pixel(415, 415);
      check_eq("corner_hit", 32'(hit), 32'd1);
      check_eq("dead_hp", 32'(hp), 32'd0);
      check_eq("dead_game_over", 32'(game_over), 32'd1);
      check_eq("dead_invuln", 32'(invuln), 32'd0);
      set_obs(405, 410);
      hit_seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         hit_seen |= hit;
      end
      set_obs(0, 0);
      check_eq("dead_no_hit", 32'(hit_seen), 32'd0);
      check_eq("dead_hp_held", 32'(hp), 32'd0);
      check_eq("dead_go_held", 32'(game_over), 32'd1);
`ifdef HIT_COUNT_EN
      check_eq("hit_count_3", 32'(hit_count), 32'd3);
`endif

      game_on = 1'b0;
      tick();
      check_eq("restart_hp", 32'(hp), 32'd3);
      check_eq("restart_game_over", 32'(game_over), 32'd0);
`ifdef HIT_COUNT_EN
      check_eq("hit_count_clear", 32'(hit_count), 32'd0);
`endif

      // Reset in the middle of invulnerability.
      game_on = 1'b1;
      tick();
      tick();
      pulse_pixel(405, 410);
      check_eq("mid_hit", 32'(hit), 32'd1);
      check_eq("mid_hp", 32'(hp), 32'd2);
      tick();
      tick();
      tick();
      check_eq("mid_invuln", 32'(invuln), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_hp", 32'(hp), 32'd3);
      check_eq("mid_rst_invuln", 32'(invuln), 32'd0);
      check_eq("mid_rst_hit", 32'(hit), 32'd0);
      check_eq("mid_rst_game_over", 32'(game_over), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/player_hit_detector.md
Name: player_hit_detector

Overview:
Consumer end of the obstacle pixel-coordinate interface. Every obstacle module drives obstacle_x/obstacle_y with hcount/vcount while it draws one of its own pixels, and drives 0 otherwise. This block compares those coordinates against the player box at the mouse position. It maintains player HP, applies a post-hit invulnerability window, and raises game_over. It sits between the obstacle mux and the game control FSM.

Parameters:
PLAYER_SIZE, 16, side of the square player box in pixels; the box spans mouse_xpos..mouse_xpos+PLAYER_SIZE-1 (same for y).
HP_MAX, 5, HP loaded on reset and on game restart.
HP_WIDTH, 4, width of hp output; must hold HP_MAX.
INVULN_TIME, 65000000, length of the invulnerability window in clk cycles (1 s at 65 MHz).

Ports:
clk  in  1  pixel clock
rst  in  1  reset, synchronous, active-high
game_on  in  1  game running; low forces IDLE
obstacle_x  in  12  obstacle pixel x; 0 = no pixel
obstacle_y  in  12  obstacle pixel y; 0 = no pixel
mouse_xpos  in  12  player box left edge
mouse_ypos  in  12  player box top edge
hp  out  HP_WIDTH  current HP
hit  out  1  one-cycle pulse per accepted hit
invuln  out  1  high while invulnerable
game_over  out  1  high when HP reaches 0; held until game_on drops

Behaviour:
- Reset: state IDLE, hp=HP_MAX, hit=0, invuln=0, game_over=0, invuln counter=0, all input registers=0.
- Stage 1: obstacle_x, obstacle_y, mouse_xpos and mouse_ypos are registered every cycle.
- Stage 2 (combinational on the stage-1 registers):
  - pix_valid = (obs_x!=0)||(obs_y!=0).
  - hit_det = pix_valid && obs_x>=mx && obs_x<=mx+PLAYER_SIZE-1 && obs_y>=my && obs_y<=my+PLAYER_SIZE-1.
  - Upper bounds are computed 13 bits wide, so no wrap at mx near 4095.
- Latency: an obstacle pixel presented in cycle N updates hit/hp/state outputs registered at the end of cycle N+1 (visible in cycle N+2).
- All outputs are registered.
- FSM states:
  - IDLE:
    - hp=HP_MAX, invuln=0, game_over=0, counter=0.
    - game_on=1 -> ARMED.
  - ARMED:
    - On hit_det: hit=1 for one cycle; hp=hp-1.
    - If hp was 1: -> DEAD, hp=0, game_over=1.
    - Otherwise: -> INVULN, counter=0, invuln=1.
  - INVULN:
    - hit_det is ignored; hit=0; counter increments each cycle.
    - When counter==INVULN_TIME-1: -> ARMED, invuln=0 (exactly INVULN_TIME cycles with invuln=1).
  - DEAD:
    - hp=0, game_over=1; hit_det ignored.
    - Exits only via game_on=0.
- Priority:
  - game_on=0 in any state -> IDLE next cycle (hp reload, flags cleared), overriding a simultaneous hit_det.
  - rst overrides everything, including mid-INVULN and DEAD.
- Multiple obstacle pixels inside the box on consecutive cycles in ARMED: only the first is counted, because the FSM leaves ARMED on that cycle.
- hp never underflows; in DEAD and INVULN it is never decremented.

Optional Feature:
HIT_COUNT_EN
- Defined:
  - Adds output hit_count [7:0]: total accepted hits since last IDLE entry.
  - Increments together with each hit pulse; saturates at 255.
  - Cleared in IDLE and on rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
Bench parameters for all scenarios: PLAYER_SIZE=16, HP_MAX=3, INVULN_TIME=10.
1. rst=1 then game_on=0 -> hp=3, hit=0, invuln=0, game_over=0; obstacle (405,410), mouse (400,400) causes nothing.
2. game_on=1, mouse (400,400), obstacle (405,410) for one cycle in cycle N -> hit=1 in cycle N+2 only; hp=2; invuln=1 for exactly 10 cycles, then 0.
3. Box edges with mouse (400,400):
   - (415,415) -> hit.
   - (416,400) -> no hit.
   - (400,399) -> no hit.
   - (0,0) -> no hit.
   - mouse (4090,4090), obstacle (5,5) -> no hit.
4. Second hit during invuln -> hp stays 2, no hit pulse; same pixel presented after invuln ends -> hp=1.
5. Third hit -> hp=0, game_over=1; further hits ignored; game_on=0 -> next cycle hp=3, game_over=0, state IDLE.
6. rst asserted mid-INVULN -> all outputs return to reset values next cycle. With HIT_COUNT_EN defined, 3 hits -> hit_count=3; game_on=0 -> hit_count=0.
